dvp_raw_receiver: RTL and testbench

DVP_RAW_RECEIVER -- requirements
Module: dvp_raw_receiver

---
 rtl/dvp_raw_receiver.sv | 138 +++++++++++++
 tb/tb_dvp_raw_receiver.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dvp_raw_receiver.sv
// DVP raw (Bayer) receiver: two-stage pipeline with frame/line framing from href and vsync.
// Optional measurement (frame size, line-length check) is compiled in with DVP_RX_MEASURE_EN.
module dvp_raw_receiver #(
    parameter int   BITS  = 8,
    parameter logic H_POL = 1'b0,
    parameter logic V_POL = 1'b1
) (
    input  logic            xclk,
    input  logic            reset_n,
    input  logic            dvp_href,
    input  logic            dvp_hsync,
    input  logic            dvp_vsync,
    input  logic [BITS-1:0] dvp_raw,
    output logic            out_valid,
    output logic [BITS-1:0] out_data,
    output logic            out_sof,
    output logic            out_eol,
    output logic            frame_done,
    output logic [15:0]     frame_width,
    output logic [15:0]     frame_height,
    output logic            err_line
);

    typedef enum logic [1:0] {SYNC, VBLANK, ACTIVE} state_t;

    state_t          state;
    logic            href_s1;
    logic            vsync_s1;
    logic            vsync_prev;
    logic [BITS-1:0] raw_s1;

    logic vs_edge;
    logic enter_active;
    logic valid_nx;
    logic eol_nx;
    logic done_nx;

    // hsync is not used for framing; href alone delimits lines.
    logic hsync_unused;
    assign hsync_unused = dvp_hsync ^ H_POL;

    assign vs_edge      = (vsync_s1 == V_POL) && (vsync_prev != V_POL);
    assign enter_active = (state == VBLANK) && href_s1 && !vs_edge;
    assign valid_nx     = href_s1 && ((state == ACTIVE) || enter_active);
    // Lookahead on raw href marks the last pixel; a vsync edge cuts the line short.
    assign eol_nx       = valid_nx && (!dvp_href || vs_edge);

    always_ff @(posedge xclk) begin
        if (!reset_n) begin
            state      <= SYNC;
            href_s1    <= 1'b0;
            vsync_s1   <= 1'b0;
            vsync_prev <= 1'b0;
            raw_s1     <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_sof    <= 1'b0;
            out_eol    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            href_s1    <= dvp_href;
            vsync_s1   <= dvp_vsync;
            raw_s1     <= dvp_raw;
            vsync_prev <= vsync_s1;
            out_valid  <= valid_nx;
            out_data   <= valid_nx ? raw_s1 : '0;
            out_sof    <= enter_active;
            out_eol    <= eol_nx;
            frame_done <= done_nx;
            case (state)
                SYNC:    if (vs_edge) state <= VBLANK;
                VBLANK:  if (!vs_edge && href_s1) state <= ACTIVE;
                ACTIVE:  if (vs_edge) state <= VBLANK;
                default: state <= SYNC;
            endcase
        end
    end

`ifdef DVP_RX_MEASURE_EN
    logic [15:0] pix_cnt;
    logic [15:0] line_cnt;
    logic [15:0] first_width;
    logic [15:0] line_len;
    logic [15:0] line_inc;

    // Width of the line ending on this pixel, saturating.
    assign line_len = (pix_cnt == 16'hFFFF) ? pix_cnt : pix_cnt + 16'd1;
    assign line_inc = (line_cnt == 16'hFFFF) ? line_cnt : line_cnt + 16'd1;
    assign done_nx  = vs_edge && (state == ACTIVE);

    always_ff @(posedge xclk) begin
        if (!reset_n) begin
            pix_cnt      <= '0;
            line_cnt     <= '0;
            first_width  <= '0;
            frame_width  <= '0;
            frame_height <= '0;
            err_line     <= 1'b0;
        end else begin
            if (valid_nx) pix_cnt <= eol_nx ? 16'd0 : line_len;
            if (eol_nx) begin
                if (line_cnt == 16'd0)
                    first_width <= line_len;
                else if (line_len != first_width)
                    err_line <= 1'b1;
            end
            if (vs_edge) begin
                line_cnt <= '0;
                if (state == ACTIVE) begin
                    frame_width  <= (eol_nx && line_cnt == 16'd0) ? line_len : first_width;
                    frame_height <= eol_nx ? line_inc : line_cnt;
                end
                if (eol_nx) err_line <= 1'b1;
            end else if (eol_nx) begin
                line_cnt <= line_inc;
            end
        end
    end
`else
    logic line_seen;

    // An eol on the edge cycle means the truncated line still counts as seen.
    assign done_nx      = vs_edge && (line_seen || eol_nx);
    assign frame_width  = '0;
    assign frame_height = '0;
    assign err_line     = 1'b0;

    always_ff @(posedge xclk) begin
        if (!reset_n)
            line_seen <= 1'b0;
        else if (vs_edge)
            line_seen <= 1'b0;
        else if (eol_nx)
            line_seen <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_dvp_raw_receiver.sv
// Bench for dvp_raw_receiver: frame-level model (armed flag, line-width list, pixel queue)
// checked against the DUT stream and the frame_done/size/error outputs.
module tb_dvp_raw_receiver;
    localparam int BITS = 8;
`ifdef DVP_RX_MEASURE_EN
    localparam bit MEAS = 1'b1;
`else
    localparam bit MEAS = 1'b0;
`endif

    logic            xclk = 1'b0;
    logic            reset_n = 1'b0;
    logic            dvp_href = 1'b0;
    logic            dvp_hsync = 1'b1;
    logic            dvp_vsync = 1'b0;
    logic [BITS-1:0] dvp_raw = '0;
    logic            out_valid;
    logic [BITS-1:0] out_data;
    logic            out_sof;
    logic            out_eol;
    logic            frame_done;
    logic [15:0]     frame_width;
    logic [15:0]     frame_height;
    logic            err_line;

    dvp_raw_receiver #(.BITS(BITS), .H_POL(1'b0), .V_POL(1'b1)) dut (
        .xclk(xclk), .reset_n(reset_n), .dvp_href(dvp_href), .dvp_hsync(dvp_hsync),
        .dvp_vsync(dvp_vsync), .dvp_raw(dvp_raw), .out_valid(out_valid), .out_data(out_data),
        .out_sof(out_sof), .out_eol(out_eol), .frame_done(frame_done),
        .frame_width(frame_width), .frame_height(frame_height), .err_line(err_line)
    );

    always #5 xclk = ~xclk;

    int checks = 0;
    int fails = 0;
    logic [BITS+1:0] exp_q[$];   // {sof, eol, data}
    int   lines_q[$];            // widths of lines sent in the current armed frame
    bit   armed = 1'b0;          // a vsync edge has been seen since reset
    bit   exp_err = 1'b0;
    int   exp_done = 0;
    int   done_cnt = 0;
    logic [15:0] exp_w = '0, exp_h = '0;
    logic [15:0] last_w = '0, last_h = '0;

    // Stream monitor
    always @(negedge xclk) begin
        logic [BITS+1:0] e;
        checks++;
        if ((out_sof || out_eol) && !out_valid) begin
            fails++;
            $display("FAIL sof_eol_qualify: sof=%0b eol=%0b with valid=0", out_sof, out_eol);
        end
        if (out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_pixel: got sof=%0b eol=%0b data=%0h, none expected",
                         out_sof, out_eol, out_data);
            end else begin
                e = exp_q.pop_front();
                if ({out_sof, out_eol, out_data} !== e) begin
                    fails++;
                    $display("FAIL pixel: got {sof,eol,data}=%0h expected %0h",
                             {out_sof, out_eol, out_data}, e);
                end
            end
        end
        if (frame_done) begin
            done_cnt++;
            last_w = frame_width;
            last_h = frame_height;
        end
    end

    task automatic tick();
        @(posedge xclk);
        #1;
    endtask

    function automatic logic [BITS-1:0] bar_pix(int row, int col);
        int bar;
        logic [BITS-1:0] r, g, b;
        bar = col % 8;
        r = ((bar >> 2) & 1) != 0 ? '1 : '0;
        g = ((bar >> 1) & 1) != 0 ? '1 : '0;
        b = (bar & 1) != 0 ? '1 : '0;
        if (row % 2 == 0) return (col % 2 == 0) ? b : g;
        else              return (col % 2 == 0) ? g : r;
    endfunction

    task automatic send_line(input int n, input bit colorbar, input int row);
        logic [BITS-1:0] d;
        bit first;
        first = armed && (lines_q.size() == 0);
        for (int i = 0; i < n; i++) begin
            d = colorbar ? bar_pix(row, i) : BITS'($urandom);
            dvp_href  = 1'b1;
            dvp_hsync = 1'($urandom_range(0, 1));
            dvp_raw   = d;
            if (armed) exp_q.push_back({first && (i == 0), i == n - 1, d});
            tick();
        end
        dvp_href  = 1'b0;
        dvp_hsync = 1'b1;
        dvp_raw   = BITS'($urandom);
        if (armed) lines_q.push_back(n);
        repeat ($urandom_range(1, 4)) tick();
    endtask

    task automatic send_frame(input int nlines, input int width, input bit colorbar);
        for (int r = 0; r < nlines; r++) send_line(width, colorbar, r);
    endtask

    task automatic frame_end_model();
        if (armed && lines_q.size() > 0) begin
            exp_done++;
            exp_w = MEAS ? 16'(lines_q[0]) : 16'd0;
            exp_h = MEAS ? 16'(lines_q.size()) : 16'd0;
            for (int i = 1; i < lines_q.size(); i++)
                if (lines_q[i] != lines_q[0]) exp_err = 1'b1;
        end
        lines_q.delete();
        armed = 1'b1;
    endtask

    task automatic check_frame(input string name);
        checks++;
        if (done_cnt !== exp_done) begin
            fails++;
            $display("FAIL %s done_count: got %0d expected %0d", name, done_cnt, exp_done);
        end
        checks++;
        if ({last_w, last_h} !== {exp_w, exp_h}) begin
            fails++;
            $display("FAIL %s frame_size: got %0dx%0d expected %0dx%0d", name, last_w, last_h, exp_w, exp_h);
        end
        checks++;
        if (err_line !== (MEAS ? exp_err : 1'b0)) begin
            fails++;
            $display("FAIL %s err_line: got %0b expected %0b", name, err_line, MEAS ? exp_err : 1'b0);
        end
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s missing_pixels: got %0d left expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic vsync_pulse(input string name);
        dvp_href  = 1'b0;
        dvp_vsync = 1'b1;
        repeat (3) tick();
        dvp_vsync = 1'b0;
        repeat (3) tick();
        frame_end_model();
        check_frame(name);
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({out_valid, out_data, out_sof, out_eol, frame_done, frame_width, frame_height, err_line} !== '0) begin
            fails++;
            $display("FAIL %s outputs_zero: got v=%0b d=%0h sof=%0b eol=%0b done=%0b w=%0d h=%0d err=%0b expected all 0",
                     name, out_valid, out_data, out_sof, out_eol, frame_done, frame_width, frame_height, err_line);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (4) begin
            dvp_href = 1'($urandom_range(0, 1));
            dvp_raw  = BITS'($urandom);
            tick();
        end
        dvp_href = 1'b0;
        tick();
        @(negedge xclk);
        check_all_zero("reset");
        reset_n = 1'b1;
        armed = 1'b0;
        exp_err = 1'b0;
        tick();
    endtask

    task automatic test_colorbar_frames();
        send_frame(4, 8, 1'b1);
        vsync_pulse("colorbar_dropped");
        send_frame(4, 8, 1'b1);
        vsync_pulse("colorbar_frame");
    endtask

    task automatic test_single_pixel_lines();
        send_frame(4, 1, 1'b0);
        vsync_pulse("single_pixel");
    endtask

    task automatic test_line_mismatch();
        send_line(8, 1'b0, 0);
        send_line(8, 1'b0, 1);
        send_line(7, 1'b0, 2);
        send_line(8, 1'b0, 3);
        vsync_pulse("short_line");
        send_frame(4, 8, 1'b0);
        vsync_pulse("sticky_err");
    endtask

    task automatic test_vsync_truncation();
        logic [BITS-1:0] d;
        send_line(8, 1'b0, 0);
        send_line(8, 1'b0, 1);
        for (int i = 0; i < 5; i++) begin
            d = BITS'($urandom);
            dvp_href = 1'b1;
            dvp_raw  = d;
            if (i == 4) dvp_vsync = 1'b1;
            exp_q.push_back({1'b0, i == 4, d});
            tick();
        end
        dvp_href = 1'b0;
        repeat (3) tick();
        dvp_vsync = 1'b0;
        repeat (3) tick();
        lines_q.push_back(5);
        exp_err = 1'b1;
        frame_end_model();
        check_frame("vsync_truncation");
    endtask

    task automatic test_reset_mid_line();
        logic [BITS-1:0] d;
        send_line(6, 1'b0, 0);
        for (int i = 0; i < 4; i++) begin
            d = BITS'($urandom);
            dvp_href = 1'b1;
            dvp_raw  = d;
            // Pixels 0 and 1 leave the pipeline before the reset edge; 2 and 3 are dropped.
            if (i < 2) exp_q.push_back({i == 0 && lines_q.size() == 0, 1'b0, d});
            if (i == 3) reset_n = 1'b0;
            tick();
        end
        reset_n = 1'b1;
        armed = 1'b0;
        exp_err = 1'b0;
        lines_q.delete();
        @(negedge xclk);
        check_all_zero("mid_line_reset");
        repeat (4) begin
            dvp_raw = BITS'($urandom);
            tick();
        end
        dvp_href = 1'b0;
        tick();
        send_line(6, 1'b0, 1);
        vsync_pulse("after_reset_dropped");
        send_frame(3, 6, 1'b0);
        vsync_pulse("after_reset_frame");
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 3; f++) begin
            send_frame($urandom_range(1, 5), $urandom_range(1, 12), 1'b0);
            vsync_pulse("random_frame");
        end
    endtask

    initial begin
        test_reset();
        test_colorbar_frames();
        test_single_pixel_lines();
        test_line_mismatch();
        test_vsync_truncation();
        test_reset_mid_line();
        test_random_frames();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
